// File: rtl/t03_inst_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM for the team_03 RV32I core.
// Optional bus-timeout watchdog enabled by defining T03_SEQ_TIMEOUT_EN.
module t03_inst_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        en,
  input  logic        i_ack,
  input  logic [31:0] inst_in,
  output logic [31:0] inst_out,
  input  logic [2:0]  type_in,
  input  logic        branch_taken,
  input  logic        d_ack,
  output logic        i_req,
  output logic        d_ren,
  output logic        d_wen,
  output logic        exec_en,
  output logic        reg_wen,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_J = 3'd4;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        is_load, is_store;

  assign is_load  = (inst_q[6:0] == 7'b0000011);
  assign is_store = (type_in == TYPE_S);

`ifdef T03_SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          start_ok;

  assign start_ok    = en && !tmo_q;
  assign timeout_err = tmo_q;
`else
  logic start_ok;

  assign start_ok    = en;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    i_req   = 1'b0;
    d_ren   = 1'b0;
    d_wen   = 1'b0;
    exec_en = 1'b0;
    reg_wen = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 1'b0;
`ifdef T03_SEQ_TIMEOUT_EN
    // Counter idles at zero so every entry into FETCH/MEM starts a fresh wait window.
    cnt_d   = '0;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: begin
        i_req = 1'b1;
        if (i_ack) begin
          inst_d  = inst_in;
          state_d = DECODE;
        end
`ifdef T03_SEQ_TIMEOUT_EN
        else if (cnt_q == LIMIT) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        exec_en = 1'b1;
        if (is_load || is_store) begin
          state_d = MEM;
        end else if (type_in == TYPE_B) begin
          pc_en   = 1'b1;
          pc_sel  = branch_taken;
          state_d = en ? FETCH : IDLE;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        d_ren = is_load;
        d_wen = !is_load;
        if (d_ack) begin
          if (is_load) begin
            state_d = WB;
          end else begin
            pc_en   = 1'b1;
            state_d = en ? FETCH : IDLE;
          end
        end
`ifdef T03_SEQ_TIMEOUT_EN
        else if (cnt_q == LIMIT) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      WB: begin
        reg_wen = (inst_q[11:7] != 5'd0);
        pc_en   = 1'b1;
        pc_sel  = (type_in == TYPE_J);
        state_d = en ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      inst_q  <= '0;
`ifdef T03_SEQ_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
`ifdef T03_SEQ_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign inst_out = inst_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_t03_inst_sequencer.sv
// Directed bench for t03_inst_sequencer: walks ALU, load, store, branch, jump,
// en-drop, reset-abort and bus-wait scenarios with hand-computed expectations.
module tb_t03_inst_sequencer;

`ifdef T03_SEQ_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 16;
`endif

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] JAL0 = 32'h0080006F;
  localparam logic [31:0] ADD  = 32'h002081B3;

  logic        clk = 1'b0;
  logic        nRst, en, i_ack, branch_taken, d_ack;
  logic [31:0] inst_in, inst_out;
  logic [2:0]  type_in;
  logic        i_req, d_ren, d_wen, exec_en, reg_wen, pc_en, pc_sel, busy, timeout_err;
  logic [7:0]  outs;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  t03_inst_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nRst(nRst), .en(en), .i_ack(i_ack), .inst_in(inst_in),
    .inst_out(inst_out), .type_in(type_in), .branch_taken(branch_taken),
    .d_ack(d_ack), .i_req(i_req), .d_ren(d_ren), .d_wen(d_wen),
    .exec_en(exec_en), .reg_wen(reg_wen), .pc_en(pc_en), .pc_sel(pc_sel),
    .busy(busy), .timeout_err(timeout_err)
  );

  // {i_req, d_ren, d_wen, exec_en, reg_wen, pc_en, pc_sel, busy}
  assign outs = {i_req, d_ren, d_wen, exec_en, reg_wen, pc_en, pc_sel, busy};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nRst = 1'b0; en = 1'b0; i_ack = 1'b0; inst_in = '0; type_in = '0;
    branch_taken = 1'b0; d_ack = 1'b0;
    #12;
    check("rst_outs", {24'd0, outs}, 32'h00);
    check("rst_inst", inst_out, 32'h0);
    check("rst_tmo", {31'd0, timeout_err}, 32'h0);

    // ADDI x1: 4-cycle ALU instruction
    @(negedge clk);
    nRst = 1'b1; en = 1'b1; inst_in = ADDI; i_ack = 1'b1; type_in = 3'd1;
    #1 check("idle_outs", {24'd0, outs}, 32'h00);
    tick(); #1 check("addi_fetch", {24'd0, outs}, 32'h81);
    tick(); i_ack = 1'b0; #1 check("addi_decode", {24'd0, outs}, 32'h01);
    check("addi_inst", inst_out, ADDI);
    tick(); #1 check("addi_exec", {24'd0, outs}, 32'h11);
    tick(); inst_in = LW; i_ack = 1'b1; #1 check("addi_wb", {24'd0, outs}, 32'h0D);

    // LW x2 with d_ack arriving in the fourth MEM cycle
    tick(); #1 check("lw_fetch", {24'd0, outs}, 32'h81);
    check("lw_inst_hold", inst_out, ADDI);
    tick(); i_ack = 1'b0; type_in = 3'd1; #1 check("lw_decode", {24'd0, outs}, 32'h01);
    tick(); #1 check("lw_exec", {24'd0, outs}, 32'h11);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) d_ack = 1'b1;
      #1 check("lw_mem", {24'd0, outs}, 32'h41);
    end
    tick(); d_ack = 1'b0; inst_in = SW; i_ack = 1'b1;
    #1 check("lw_wb", {24'd0, outs}, 32'h0D);

    // SW: single MEM cycle, PC+4, no register write
    tick(); #1 check("sw_fetch", {24'd0, outs}, 32'h81);
    tick(); i_ack = 1'b0; type_in = 3'd2; #1 check("sw_decode", {24'd0, outs}, 32'h01);
    tick(); #1 check("sw_exec", {24'd0, outs}, 32'h11);
    tick(); d_ack = 1'b1; #1 check("sw_mem", {24'd0, outs}, 32'h25);

    // BEQ taken, then not taken
    tick(); d_ack = 1'b0; inst_in = BEQ; i_ack = 1'b1;
    #1 check("beq1_fetch", {24'd0, outs}, 32'h81);
    tick(); i_ack = 1'b0; type_in = 3'd3; #1 check("beq1_decode", {24'd0, outs}, 32'h01);
    tick(); branch_taken = 1'b1; #1 check("beq1_exec", {24'd0, outs}, 32'h17);
    tick(); branch_taken = 1'b0; i_ack = 1'b1; #1 check("beq2_fetch", {24'd0, outs}, 32'h81);
    tick(); i_ack = 1'b0; #1 check("beq2_decode", {24'd0, outs}, 32'h01);
    tick(); #1 check("beq2_exec", {24'd0, outs}, 32'h15);

    // JAL x0: jump target, rd=x0 write suppressed
    tick(); inst_in = JAL0; i_ack = 1'b1; #1 check("jal_fetch", {24'd0, outs}, 32'h81);
    tick(); i_ack = 1'b0; type_in = 3'd4; #1 check("jal_decode", {24'd0, outs}, 32'h01);
    tick(); #1 check("jal_exec", {24'd0, outs}, 32'h11);
    tick(); #1 check("jal_wb", {24'd0, outs}, 32'h07);

    // ADD x3 with stray i_ack after fetch and en dropped in EXEC
    tick(); inst_in = ADD; i_ack = 1'b1; #1 check("add_fetch", {24'd0, outs}, 32'h81);
    tick(); inst_in = 32'hDEADBEEF; type_in = 3'd0; #1 check("add_decode", {24'd0, outs}, 32'h01);
    check("add_inst_dec", inst_out, ADD);
    tick(); en = 1'b0; #1 check("add_exec", {24'd0, outs}, 32'h11);
    check("add_inst_exec", inst_out, ADD);
    tick(); i_ack = 1'b0; #1 check("add_wb", {24'd0, outs}, 32'h0D);
    tick(); #1 check("add_idle", {24'd0, outs}, 32'h00);
    tick(); #1 check("idle_hold", {24'd0, outs}, 32'h00);

    // Reset asserted while a load waits in MEM
    en = 1'b1; inst_in = LW; i_ack = 1'b1;
    tick(); #1 check("rlw_fetch", {24'd0, outs}, 32'h81);
    tick(); i_ack = 1'b0; type_in = 3'd1;
    tick();
    tick(); #1 check("rlw_mem", {24'd0, outs}, 32'h41);
    #2 nRst = 1'b0;
    #1 check("rlw_abort", {24'd0, outs}, 32'h00);
    check("rlw_inst_clr", inst_out, 32'h0);
    @(negedge clk);
    nRst = 1'b1; en = 1'b1; i_ack = 1'b0;

`ifdef T03_SEQ_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      tick(); #1 check("tmo_fetch_wait", {24'd0, outs}, 32'h81);
    end
    tick(); #1 check("tmo_idle", {24'd0, outs}, 32'h00);
    check("tmo_flag", {31'd0, timeout_err}, 32'h1);
    tick(); #1 check("tmo_en_ignored", {24'd0, outs}, 32'h00);
`else
    for (int i = 0; i < 20; i++) tick();
    #1 check("wait_no_tmo", {24'd0, outs}, 32'h81);
    check("tmo_tied", {31'd0, timeout_err}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
